// File: rtl/lane_combine_pkg.sv
// Shared mode encodings and the bitwise lane-combine operator.
// Vectors are carried at LANE_MAX width so one function serves any LANES <= LANE_MAX.
package lane_combine_pkg;

  localparam logic [1:0] MODE_SEL  = 2'd0;
  localparam logic [1:0] MODE_AND  = 2'd1;
  localparam logic [1:0] MODE_XOR  = 2'd2;
  localparam logic [1:0] MODE_PASS = 2'd3;

  localparam int LANE_MAX = 64;

  typedef logic [LANE_MAX-1:0] lane_vec_t;

  // SEL picks a where a is set, else b, which reduces to a|b per lane.
  function automatic lane_vec_t lane_op(
    input logic [1:0] mode,
    input lane_vec_t  a,
    input lane_vec_t  b
  );
    lane_vec_t r;
    r = '0;
    case (mode)
      MODE_SEL:  r = a | b;
      MODE_AND:  r = a & b;
      MODE_XOR:  r = a ^ b;
      MODE_PASS: r = a;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// Synchronous valid/ready FIFO; pointers carry one extra MSB so full and empty
// are distinguishable without an occupancy counter.
module lane_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  wr_ptr_next;
  logic [AW:0]  rd_ptr_reg;
  logic [AW:0]  rd_ptr_next;
  logic [W-1:0] mem [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A full FIFO refuses pushes even when the head is popped in the same cycle.
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = ~empty & out_ready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, 1'b1};
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage needs no reset: stale entries are never visible while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= in_data;
    end
  end

  assign out_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/lane_combine_pipe.sv
// Per-lane operand combine feeding a result FIFO, plus an independent
// rising-edge capture channel with a saturating event counter.
module lane_combine_pipe
  import lane_combine_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 2,
  parameter int CAP_W = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] in1,
  input  logic [LANES-1:0] in2,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_lanes,
  input  logic [CAP_W-1:0] cap_in,
  output logic [CAP_W-1:0] cap_out,
  output logic [CNT_W-1:0] cap_cnt
);

  // LANES must not exceed LANE_MAX; the operator runs at the wide width.
  lane_vec_t        a_wide;
  lane_vec_t        b_wide;
  lane_vec_t        op_full;
  logic [LANES-1:0] lane_res;
  logic             op_unused;

  assign a_wide  = LANE_MAX'(in1);
  assign b_wide  = LANE_MAX'(in2);
  assign op_full = lane_op(mode, a_wide, b_wide);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_res[gi] = op_full[gi];
    end
  endgenerate

  // Lanes above LANES are always zero; fold them away explicitly.
  assign op_unused = ^op_full;

  lane_fifo #(
    .W     (LANES),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (lane_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_lanes)
  );

  logic [CAP_W-1:0] cap_prev_reg;
  logic [CAP_W-1:0] cap_out_reg;
  logic [CAP_W-1:0] cap_out_next;
  logic [CNT_W-1:0] cap_cnt_reg;
  logic [CNT_W-1:0] cap_cnt_next;
  logic [CAP_W-1:0] rise;
  logic             any_rise;

  // Several bits rising together form a single capture event.
  assign rise     = cap_in & ~cap_prev_reg;
  assign any_rise = |rise;

  always_comb begin
    cap_out_next = cap_out_reg;
    cap_cnt_next = cap_cnt_reg;
    if (any_rise) begin
      cap_out_next = cap_in;
      if (cap_cnt_reg != {CNT_W{1'b1}}) begin
        cap_cnt_next = cap_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_prev_reg <= '0;
      cap_out_reg  <= '0;
      cap_cnt_reg  <= '0;
    end else begin
      cap_prev_reg <= cap_in;
      cap_out_reg  <= cap_out_next;
      cap_cnt_reg  <= cap_cnt_next;
    end
  end

  assign cap_out = cap_out_reg;
  assign cap_cnt = cap_cnt_reg;

endmodule

// File: tb/tb_lane_combine_pipe.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed literal checks for ops, backpressure, capture and reset.
module tb_lane_combine_pipe;

  localparam int LANES = 4;
  localparam int DEPTH = 2;
  localparam int CAP_W = 2;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] in1;
  logic [LANES-1:0] in2;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out_lanes;
  logic [CAP_W-1:0] cap_in;
  logic [CAP_W-1:0] cap_out;
  logic [CNT_W-1:0] cap_cnt;

  logic             sat_unused_in_ready;
  logic             sat_unused_out_valid;
  logic [LANES-1:0] sat_unused_out_lanes;
  logic [CAP_W-1:0] sat_unused_cap_out;
  logic [1:0]       sat_cnt;

  lane_combine_pipe #(
    .LANES (LANES), .DEPTH (DEPTH), .CAP_W (CAP_W), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
    .in1 (in1), .in2 (in2), .mode (mode), .out_valid (out_valid),
    .out_ready (out_ready), .out_lanes (out_lanes), .cap_in (cap_in),
    .cap_out (cap_out), .cap_cnt (cap_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  lane_combine_pipe #(
    .LANES (LANES), .DEPTH (DEPTH), .CAP_W (CAP_W), .CNT_W (2)
  ) dut_sat (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (sat_unused_in_ready),
    .in1 (in1), .in2 (in2), .mode (mode), .out_valid (sat_unused_out_valid),
    .out_ready (out_ready), .out_lanes (sat_unused_out_lanes), .cap_in (cap_in),
    .cap_out (sat_unused_cap_out), .cap_cnt (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Reference model: FIFO as a queue, capture as plain edge arithmetic.
  logic [LANES-1:0] q[$];
  logic [CAP_W-1:0] m_prev;
  logic [CAP_W-1:0] m_cap;
  int               m_cnt;
  int               m_cnt_sat;
  logic             m_push;
  logic             m_pop;
  logic [LANES-1:0] m_res;
  logic [CAP_W-1:0] m_rise;

  function automatic logic [LANES-1:0] model_op(input logic [1:0] md,
                                                input logic [LANES-1:0] a,
                                                input logic [LANES-1:0] b);
    logic [LANES-1:0] r;
    for (int i = 0; i < LANES; i++) begin
      case (md)
        2'd0:    r[i] = a[i] ? a[i] : b[i];
        2'd1:    r[i] = a[i] && b[i];
        2'd2:    r[i] = (a[i] != b[i]);
        default: r[i] = a[i];
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_prev    = '0;
      m_cap     = '0;
      m_cnt     = 0;
      m_cnt_sat = 0;
    end else begin
      m_push = in_valid && (q.size() < DEPTH);
      m_pop  = (q.size() > 0) && out_ready;
      m_res  = model_op(mode, in1, in2);
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(m_res);
      m_rise = cap_in & ~m_prev;
      if (m_rise != 0) begin
        m_cap = cap_in;
        if (m_cnt < 15) m_cnt++;
        if (m_cnt_sat < 3) m_cnt_sat++;
      end
      m_prev = cap_in;
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("out_lanes", 32'(out_lanes), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk("cap_out",   32'(cap_out),   32'(m_cap));
    chk("cap_cnt",   32'(cap_cnt),   32'(m_cnt));
    chk("sat_cnt",   32'(sat_cnt),   32'(m_cnt_sat));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] md, input logic ordy);
    in_valid  = v;
    in1       = a;
    in2       = b;
    mode      = md;
    out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'b0, 4'b0, 2'd0, 1'b0);
    cap_in = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_lanes", 32'(out_lanes), 32'd0);
    chk("rst_cap_cnt",   32'(cap_cnt),   32'd0);

    // Ops: one push per mode with continuous draining.
    drive(1'b1, 4'b1010, 4'b0110, 2'd0, 1'b1);
    #1;
    chk("no_bypass", 32'(out_valid), 32'd0);
    step(); chk("op_sel",  32'(out_lanes), 32'b1110);
    mode = 2'd1;
    step(); chk("op_and",  32'(out_lanes), 32'b0010);
    mode = 2'd2;
    step(); chk("op_xor",  32'(out_lanes), 32'b1100);
    mode = 2'd3;
    step(); chk("op_pass", 32'(out_lanes), 32'b1010);
    in_valid = 1'b0;
    step(); chk("op_drained", 32'(out_valid), 32'd0);

    // Backpressure: third push refused while full.
    drive(1'b1, 4'b0001, 4'b0000, 2'd3, 1'b0);
    step(); chk("bp_ready1", 32'(in_ready), 32'd1);
    in1 = 4'b0010;
    step(); chk("bp_full", 32'(in_ready), 32'd0);
    chk("bp_head", 32'(out_lanes), 32'b0001);
    in1 = 4'b0100;
    step(); chk("bp_hold", 32'(out_lanes), 32'b0001);
    chk("bp_still_full", 32'(in_ready), 32'd0);
    drive(1'b0, 4'b0, 4'b0, 2'd3, 1'b1);
    step(); chk("bp_second", 32'(out_lanes), 32'b0010);
    step(); chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_zero", 32'(out_lanes), 32'd0);

    // Full + pop: the pop happens alone, the push lands a cycle later.
    drive(1'b1, 4'b0011, 4'b0000, 2'd3, 1'b0);
    step();
    in1 = 4'b0101;
    step(); chk("fp_full", 32'(in_ready), 32'd0);
    drive(1'b1, 4'b1111, 4'b0000, 2'd3, 1'b1);
    step(); chk("fp_pop_only", 32'(out_lanes), 32'b0101);
    chk("fp_count1", 32'(in_ready), 32'd1);
    step(); chk("fp_push_after", 32'(out_lanes), 32'b1111);
    in_valid = 1'b0;
    step(); chk("fp_empty", 32'(out_valid), 32'd0);

    // Capture channel.
    out_ready = 1'b0;
    cap_in = 2'b01;
    step(); chk("cap_01", 32'(cap_out), 32'b01); chk("cnt_1", 32'(cap_cnt), 32'd1);
    step(); step(); chk("cnt_held", 32'(cap_cnt), 32'd1);
    cap_in = 2'b11;
    step(); chk("cap_11", 32'(cap_out), 32'b11); chk("cnt_2", 32'(cap_cnt), 32'd2);
    cap_in = 2'b00;
    step(); chk("cap_fall", 32'(cap_out), 32'b11);
    cap_in = 2'b11;
    step(); chk("cnt_3", 32'(cap_cnt), 32'd3);
    for (int i = 0; i < 2; i++) begin
      cap_in = 2'b00; step();
      cap_in = 2'b11; step();
    end
    chk("cnt_5", 32'(cap_cnt), 32'd5);
    chk("sat_3", 32'(sat_cnt), 32'd3);
    cap_in = 2'b00;
    step();

    // Randomized traffic, checked by the model on every cycle.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
      cap_in = 2'($urandom);
      step();
    end

    // Reset during traffic: one queued entry and cap_cnt of 2.
    drive(1'b0, 4'b0, 4'b0, 2'd0, 1'b0);
    cap_in = 2'b00;
    rst = 1'b1; step(); rst = 1'b0;
    cap_in = 2'b01; step();
    cap_in = 2'b00; step();
    cap_in = 2'b01; step();
    cap_in = 2'b00;
    drive(1'b1, 4'b0110, 4'b0000, 2'd3, 1'b0);
    step(); in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_cnt",   32'(cap_cnt),   32'd2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_ready", 32'(in_ready),  32'd1);
    chk("async_lanes", 32'(out_lanes), 32'd0);
    chk("async_cap",   32'(cap_out),   32'd0);
    chk("async_cnt",   32'(cap_cnt),   32'd0);
    step();
    rst = 1'b0;
    drive(1'b1, 4'b1001, 4'b0000, 2'd3, 1'b0);
    #1;
    chk("post_rst_nobypass", 32'(out_valid), 32'd0);
    step(); in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_lanes", 32'(out_lanes), 32'b1001);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
